nibble_add_sequencer: RTL
=========================

// Module: nibble_add_sequencer
// PURPOSE
//  Requester for the 4-bit cla_adder en/ready handshake. Accepts one WIDTH-bit add request,
//  sends it to a single cla_adder one nibble at a time (LSB first), chains the carry, and
//  returns the full sum. Sits between the 8-bit datapath/control and the shared 4-bit adder.
// PARAMETERS
//  NIBBLES  2   number of 4-bit slices; WIDTH = 4*NIBBLES (8 for the 8-bit machine)
//  TIMEOUT  15  max cycles to wait for any expected add_ready level before aborting
// PORTS
//  clk        in   1      clock; all state updates on posedge
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      request pulse; sampled only in IDLE
//  a, b       in   WIDTH  operands, latched on an accepted start
//  c_in       in   1      carry in, latched on an accepted start
//  sub        in   1      subtract request, latched on an accepted start (see CONFIGURATION)
//  busy       out  1      high from the cycle after an accepted start until done
//  done       out  1      one-cycle pulse: result/c_out/error valid
//  result     out  WIDTH  sum, held until the next accepted start
//  c_out      out  1      carry out of top nibble, held like result
//  error      out  1      set with done on timeout, cleared on next accepted start
//  add_en     out  1      to cla_adder en
//  add_a      out  4      to cla_adder A
//  add_b      out  4      to cla_adder B
//  add_c_in   out  1      to cla_adder c_in
//  add_ready  in   1      from cla_adder ready
//  add_sum    in   4      from cla_adder Output
//  add_c_out  in   1      from cla_adder c_out
// BEHAVIOUR
//  Reset: every output is 0; state IDLE; nibble index 0; timeout counter 0.
//  FSM: IDLE -> RELEASE -> ISSUE -> (RELEASE | DONE) -> IDLE.
//  IDLE: start=1 latches a, b, c_in, sub; clears error; idx=0; next state RELEASE. start=0: stay.
//  RELEASE: add_en=0. Waits until add_ready=0 (clears a stale ready). Then ISSUE.
//  ISSUE: add_en=1. add_a, add_b, add_c_in are registered and stable for the whole state.
//   add_a/add_b = nibble idx; add_c_in = latched c_in for idx 0, else the carry stored last.
//   On the first cycle with add_ready=1: store add_sum into result[4*idx+:4] and add_c_out
//   as the chain carry. If idx<NIBBLES-1, increment idx and go to RELEASE. Else go to DONE.
//  DONE: one cycle. done=1, busy=0, c_out=final carry, add_en=0. Next state IDLE.
//  Handshake: add_en stays high until ready is seen, then drops for at least one cycle.
//   Operands never change while add_en=1.
//  Latency with zero-wait adder: done is 2*NIBBLES+1 cycles after the start edge (5 for NIBBLES=2).
//  Timeout: the counter resets on each entry to RELEASE or ISSUE. If it reaches TIMEOUT
//   while the state still waits, go to DONE with error=1 and add_en=0.
//   result keeps the nibbles completed so far; upper nibbles read 0; c_out=0.
//  start while busy or in DONE: ignored (no queueing).
//  Changes to a, b or sub after acceptance: no effect.
//  Reset mid-operation: immediate return to reset values. add_en drops asynchronously.
//  Carry-out of the top nibble is reported as-is. No wrap flag beyond c_out.
// CONFIGURATION
//  NIBBLE_SEQ_SUB_EN defined: when sub=1 the block latches ~b and forces the chain carry-in to 1.
//   This gives result = a - b mod 2^WIDTH, with c_out=1 meaning no borrow.
//  Undefined: sub is ignored and the block only adds. Port list is identical in both builds.
// TESTING  (NIBBLES=2, TIMEOUT=15, behavioural cla_adder model with 1-cycle ready)
//  a=8'h3A b=8'h2F c_in=0 start -> adder sees (A,F,0) then (3,2,1); result=8'h69 c_out=0.
//  a=8'hFF b=8'h01 c_in=0 -> result=8'h00 c_out=1. a=8'h00 b=8'h00 c_in=1 -> result=8'h01.
//  Second start pulse while busy -> ignored; only one done; result of the first request.
//  Model never raises ready -> done with error=1 at 15 cycles into ISSUE; add_en=0; result=8'h00.
//  Model holds ready=1 at start -> add_en stays 0 until ready falls; then normal completion.
//  rst_n low mid-ISSUE -> all outputs 0; the next start completes correctly.
//  With NIBBLE_SEQ_SUB_EN: a=8'h10 b=8'h01 sub=1 -> 8'h0F c_out=1. Without it -> 8'h11.

Source files
------------

// File: rtl/nibble_add_sequencer.sv
// Drives a shared 4-bit adder one nibble at a time with a chained carry.
// Define NIBBLE_SEQ_SUB_EN to honour the sub input (a - b via ~b and carry-in 1).
module nibble_add_sequencer #(
    parameter int NIBBLES = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 c_in,
    input  logic                 sub,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 c_out,
    output logic                 error,
    output logic                 add_en,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_c_in,
    input  logic                 add_ready,
    input  logic [3:0]           add_sum,
    input  logic                 add_c_out
);

    localparam int WIDTH = 4 * NIBBLES;
    localparam int IW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int CW    = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RELEASE,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_timeout;
    logic             w_cnt_hit;
    logic             w_last;
    logic [WIDTH-1:0] w_b_in;
    logic             w_cin_in;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_cin;
    logic [IW-1:0]    r_idx;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_result;
    logic             r_c_out;
    logic             r_error;
    logic [3:0]       r_add_a;
    logic [3:0]       r_add_b;
    logic             r_add_c_in;

`ifdef NIBBLE_SEQ_SUB_EN
    assign w_b_in   = b ^ {WIDTH{sub}};
    assign w_cin_in = c_in | sub;
`else
    logic w_unused_sub;
    assign w_unused_sub = sub;
    assign w_b_in       = b;
    assign w_cin_in     = c_in;
`endif

    assign w_cnt_hit = (r_cnt == CW'(TIMEOUT - 1));
    assign w_last    = (r_idx == IW'(NIBBLES - 1));

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_RELEASE;
            end
            S_RELEASE: begin
                if (!add_ready) begin
                    w_next = S_ISSUE;
                end else if (w_cnt_hit) begin
                    w_next    = S_DONE;
                    w_timeout = 1'b1;
                end
            end
            S_ISSUE: begin
                if (add_ready) begin
                    w_next = w_last ? S_DONE : S_RELEASE;
                end else if (w_cnt_hit) begin
                    w_next    = S_DONE;
                    w_timeout = 1'b1;
                end
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_cin      <= 1'b0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_carry    <= 1'b0;
            r_result   <= '0;
            r_c_out    <= 1'b0;
            r_error    <= 1'b0;
            r_add_a    <= 4'h0;
            r_add_b    <= 4'h0;
            r_add_c_in <= 1'b0;
        end else begin
            r_state <= w_next;
            // Wait counter restarts on every state entry
            if (w_next != r_state)
                r_cnt <= '0;
            else if (r_state == S_RELEASE || r_state == S_ISSUE)
                r_cnt <= r_cnt + 1'b1;

            if (r_state == S_IDLE && start) begin
                r_a      <= a;
                r_b      <= w_b_in;
                r_cin    <= w_cin_in;
                r_idx    <= '0;
                r_error  <= 1'b0;
                r_result <= '0;
                r_c_out  <= 1'b0;
            end

            if (r_state == S_RELEASE && !add_ready) begin
                r_add_a    <= r_a[4*r_idx +: 4];
                r_add_b    <= r_b[4*r_idx +: 4];
                r_add_c_in <= (r_idx == '0) ? r_cin : r_carry;
            end

            if (r_state == S_ISSUE && add_ready) begin
                r_result[4*r_idx +: 4] <= add_sum;
                r_carry                <= add_c_out;
                if (!w_last) r_idx <= r_idx + 1'b1;
            end

            if (w_next == S_DONE && r_state != S_DONE) begin
                r_error <= w_timeout;
                r_c_out <= w_timeout ? 1'b0 : add_c_out;
            end
        end
    end

    assign busy     = (r_state == S_RELEASE) || (r_state == S_ISSUE);
    assign done     = (r_state == S_DONE);
    assign add_en   = (r_state == S_ISSUE);
    assign result   = r_result;
    assign c_out    = r_c_out;
    assign error    = r_error;
    assign add_a    = r_add_a;
    assign add_b    = r_add_b;
    assign add_c_in = r_add_c_in;

endmodule
